// File: rtl/prgm_mem_pkg.sv
// Shared types and default sizing for the program-memory sequencing controller.
// Optional feature macro used by this slice: PRGM_ARB_RR_EN (round-robin load/fetch arbitration).
package prgm_mem_pkg;

    localparam int ADDR_W_DEF    = 6;
    localparam int DATA_W_DEF    = 8;
    localparam int RD_CYCLES_DEF = 2;
    localparam int WR_CYCLES_DEF = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        ERS
    } state_t;

    // Phase counter width: enough to count 0..N-1 for the longer of the two hold phases.
    function automatic int cnt_width(input int rd_cycles, input int wr_cycles);
        int longest;
        longest = (rd_cycles > wr_cycles) ? rd_cycles : wr_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/prgm_arb.sv
// Two-way load/fetch arbiter producing a one-hot winner (bit 0 = load, bit 1 = fetch).
// With PRGM_ARB_RR_EN defined a last-served pointer alternates on contention; otherwise load always wins.
module prgm_arb
    import prgm_mem_pkg::*;
(
`ifdef PRGM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       take,
`endif
    input  logic       load_req,
    input  logic       fetch_req,
    output logic [1:0] winner
);

`ifdef PRGM_ARB_RR_EN
    // Reset value 0 means "fetch was served last", so load is favoured first.
    logic last_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_load <= 1'b0;
        end else if (take) begin
            last_load <= winner[0];
        end
    end

    always_comb begin
        winner = 2'b00;
        if (load_req && fetch_req) begin
            winner = last_load ? 2'b10 : 2'b01;
        end else if (load_req) begin
            winner = 2'b01;
        end else if (fetch_req) begin
            winner = 2'b10;
        end
    end
`else
    always_comb begin
        winner = 2'b00;
        if (load_req) begin
            winner = 2'b01;
        end else if (fetch_req) begin
            winner = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/prgm_mem_ctrl.sv
// Sequencer/arbiter in front of the 64x8 program memory: holds memory inputs for read/write, pulses erase.
// Optional macro PRGM_ARB_RR_EN switches load/fetch arbitration from strict load-first to round-robin.
module prgm_mem_ctrl
    import prgm_mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_CYCLES = RD_CYCLES_DEF,
    parameter int WR_CYCLES = WR_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_adrs,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_adrs,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_gnt,
    output logic              load_done,
    input  logic              erase_req,
    output logic              erase_done,
    output logic [ADDR_W-1:0] mem_adrs,
    output logic              mem_mode,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_erase,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy
);

    localparam int CNT_W = cnt_width(RD_CYCLES, WR_CYCLES);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] adrs_nxt;
    logic [DATA_W-1:0] data_nxt, fdata_nxt;
    logic              mode_nxt, erase_nxt, fvalid_nxt, ldone_nxt, edone_nxt, busy_nxt;
    logic              is_idle, erase_take, arb_en;
    logic [1:0]        winner;

    // The erase requester holds its request through the erase_done cycle, so ignore it then.
    assign is_idle    = (state == IDLE);
    assign erase_take = is_idle && erase_req && !erase_done;
    assign arb_en     = is_idle && !erase_take;
    assign load_gnt   = arb_en && winner[0];
    assign fetch_gnt  = arb_en && winner[1];

    prgm_arb u_arb (
`ifdef PRGM_ARB_RR_EN
        .clk       (clk),
        .rst_n     (rst_n),
        .take      (load_gnt || fetch_gnt),
`endif
        .load_req  (load_req),
        .fetch_req (fetch_req),
        .winner    (winner)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        adrs_nxt   = mem_adrs;
        data_nxt   = mem_data;
        fdata_nxt  = fetch_data;
        mode_nxt   = 1'b0;
        erase_nxt  = 1'b0;
        fvalid_nxt = 1'b0;
        ldone_nxt  = 1'b0;
        edone_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (erase_take) begin
                    state_nxt = ERS;
                    erase_nxt = 1'b1;
                end else if (load_gnt) begin
                    state_nxt = WR;
                    adrs_nxt  = load_adrs;
                    data_nxt  = load_data;
                    mode_nxt  = 1'b1;
                end else if (fetch_gnt) begin
                    state_nxt = RD;
                    adrs_nxt  = fetch_adrs;
                end
            end
            RD: begin
                if (cnt == RD_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = CAP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            CAP: begin
                fdata_nxt  = mem_out;
                fvalid_nxt = 1'b1;
                state_nxt  = IDLE;
            end
            WR: begin
                // mode stays high through the last WR cycle and drops together with load_done.
                if (cnt == WR_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    ldone_nxt = 1'b1;
                end else begin
                    cnt_nxt  = cnt + CNT_W'(1);
                    mode_nxt = 1'b1;
                end
            end
            ERS: begin
                state_nxt = IDLE;
                edone_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_adrs    <= '0;
            mem_data    <= '0;
            mem_mode    <= 1'b0;
            mem_erase   <= 1'b0;
            fetch_data  <= '0;
            fetch_valid <= 1'b0;
            load_done   <= 1'b0;
            erase_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            mem_adrs    <= adrs_nxt;
            mem_data    <= data_nxt;
            mem_mode    <= mode_nxt;
            mem_erase   <= erase_nxt;
            fetch_data  <= fdata_nxt;
            fetch_valid <= fvalid_nxt;
            load_done   <= ldone_nxt;
            erase_done  <= edone_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_prgm_mem_ctrl.sv
// Self-checking bench for prgm_mem_ctrl with a behavioural 64x8 memory and a byte-array reference.
// Expectations for load/fetch ordering follow PRGM_ARB_RR_EN when it is defined.
module tb_prgm_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fetch_req = 1'b0;
    logic [5:0] fetch_adrs = '0;
    logic       fetch_gnt, fetch_valid;
    logic [7:0] fetch_data;
    logic       load_req = 1'b0;
    logic [5:0] load_adrs = '0;
    logic [7:0] load_data = '0;
    logic       load_gnt, load_done;
    logic       erase_req = 1'b0;
    logic       erase_done;
    logic [5:0] mem_adrs;
    logic       mem_mode;
    logic [7:0] mem_data;
    logic       mem_erase;
    logic [7:0] mem_out = '0;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode_hi_cnt = 0;
    int erase_hi_cnt = 0;

    logic [7:0] mem [64];
    logic [7:0] rd_stage = '0;
    int         wr_cnt = 0;
    logic [7:0] ref_mem [64];
    bit         known [64];

    prgm_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_adrs(fetch_adrs), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .load_req(load_req), .load_adrs(load_adrs), .load_data(load_data),
        .load_gnt(load_gnt), .load_done(load_done),
        .erase_req(erase_req), .erase_done(erase_done),
        .mem_adrs(mem_adrs), .mem_mode(mem_mode), .mem_data(mem_data),
        .mem_erase(mem_erase), .mem_out(mem_out), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: two-stage read pipeline, write commits after three consecutive mode=1 cycles.
    always @(posedge clk) begin
        rd_stage <= mem[mem_adrs];
        mem_out  <= rd_stage;
        if (mem_erase) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'hFF;
        end else if (mem_mode) begin
            if (wr_cnt == 2) mem[mem_adrs] <= mem_data;
            wr_cnt <= wr_cnt + 1;
        end else begin
            wr_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        if (mem_mode) mode_hi_cnt++;
        if (mem_erase) erase_hi_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clk);
        fetch_req = 0; load_req = 0; erase_req = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [7:0] d, output int tg, output int td);
        @(negedge clk);
        load_adrs = a; load_data = d; load_req = 1; tg = -1; td = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (load_gnt) begin tg = cyc; break; end
            @(negedge clk);
        end
        @(negedge clk);
        load_req = 0;
        for (int i = 0; i < 40; i++) begin
            if (load_done) begin td = cyc; break; end
            @(negedge clk);
        end
        if (tg >= 0) begin ref_mem[a] = d; known[a] = 1; end
    endtask

    task automatic do_read(input logic [5:0] a, output int tg, output int tv, output logic [7:0] dat);
        @(negedge clk);
        fetch_adrs = a; fetch_req = 1; tg = -1; tv = -1; dat = 8'h00;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (fetch_gnt) begin tg = cyc; break; end
            @(negedge clk);
        end
        @(negedge clk);
        fetch_req = 0;
        for (int i = 0; i < 40; i++) begin
            if (fetch_valid) begin tv = cyc; dat = fetch_data; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, mem_mode, mem_erase, fetch_valid, load_done, erase_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_held_ctrl: got %b want 000000",
                     {busy, mem_mode, mem_erase, fetch_valid, load_done, erase_done});
        end
        rst_n = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, mem_mode, mem_erase, fetch_valid, load_done, erase_done, fetch_gnt, load_gnt} !== 8'b0) begin
            errors++;
            $display("FAIL reset_idle_ctrl: got %b want 00000000",
                     {busy, mem_mode, mem_erase, fetch_valid, load_done, erase_done, fetch_gnt, load_gnt});
        end
        checks++;
        if ({mem_adrs, mem_data, fetch_data} !== 22'b0) begin
            errors++;
            $display("FAIL reset_data: adrs=%0h data=%0h fdata=%0h want 0", mem_adrs, mem_data, fetch_data);
        end
    endtask

    task automatic test_write_read();
        int tg, td, tv;
        logic [7:0] dat, v;
        logic [5:0] a;
        for (int k = 4; k <= 7; k++) begin
            if (k != 5) begin
                v = 8'($urandom_range(255, 0));
                do_write(6'(k), v, tg, td);
            end
        end
        @(negedge clk);
        mode_hi_cnt = 0;
        do_write(6'd5, 8'hA7, tg, td);
        checks++;
        if (tg < 0 || td - tg != 4) begin
            errors++;
            $display("FAIL write_latency: gnt=%0d done=%0d want done=gnt+4", tg, td);
        end
        checks++;
        if (mode_hi_cnt != 3) begin
            errors++;
            $display("FAIL write_mode_cycles: got %0d want 3", mode_hi_cnt);
        end
        do_read(6'd5, tg, tv, dat);
        checks++;
        if (tg < 0 || tv - tg != 4) begin
            errors++;
            $display("FAIL read_latency: gnt=%0d valid=%0d want valid=gnt+4", tg, tv);
        end
        checks++;
        if (dat !== 8'hA7) begin
            errors++;
            $display("FAIL read_a7: got %0h want a7", dat);
        end
        for (int k = 4; k <= 7; k++) begin
            if (k != 5) begin
                do_read(6'(k), tg, tv, dat);
                checks++;
                if (dat !== ref_mem[k]) begin
                    errors++;
                    $display("FAIL neighbour_%0d: got %0h want %0h", k, dat, ref_mem[k]);
                end
            end
        end
        for (int n = 0; n < 12; n++) begin
            a = 6'($urandom_range(63, 0));
            if ($urandom_range(1, 0) == 1) begin
                do_write(a, 8'($urandom_range(255, 0)), tg, td);
            end else begin
                do_read(a, tg, tv, dat);
                if (known[a]) begin
                    checks++;
                    if (dat !== ref_mem[a] || tv - tg != 4) begin
                        errors++;
                        $display("FAIL random_read a=%0d: got %0h lat %0d want %0h lat 4",
                                 a, dat, tv - tg, ref_mem[a]);
                    end
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int c0, te, tl, tf, tv, tg2, tv2;
        logic [5:0] la, fa;
        logic [7:0] ld, fd, dat;
        apply_reset();
        la = 6'($urandom_range(63, 0));
        fa = la ^ 6'd1;
        ld = 8'($urandom_range(254, 0));
        te = -1; tl = -1; tf = -1; tv = -1; fd = 8'h00;
        @(negedge clk);
        erase_hi_cnt = 0;
        c0 = cyc;
        erase_req = 1;
        load_req = 1; load_adrs = la; load_data = ld;
        fetch_req = 1; fetch_adrs = fa;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (load_gnt && tl < 0) tl = cyc;
            if (fetch_gnt && tf < 0) tf = cyc;
            @(negedge clk);
            if (tl >= 0) load_req = 0;
            if (tf >= 0) fetch_req = 0;
            if (erase_done && te < 0) begin te = cyc; erase_req = 0; end
            if (fetch_valid && tv < 0) begin tv = cyc; fd = fetch_data; end
        end
        erase_req = 0; load_req = 0; fetch_req = 0;
        for (int i = 0; i < 64; i++) begin ref_mem[i] = 8'hFF; known[i] = 1; end
        ref_mem[la] = ld;
        checks++;
        if (te != c0 + 2) begin
            errors++;
            $display("FAIL sim_erase_done: cycle %0d want %0d", te, c0 + 2);
        end
        checks++;
        if (tl != c0 + 2) begin
            errors++;
            $display("FAIL sim_load_gnt: cycle %0d want %0d", tl, c0 + 2);
        end
        checks++;
        if (tf != c0 + 6) begin
            errors++;
            $display("FAIL sim_fetch_gnt: cycle %0d want %0d", tf, c0 + 6);
        end
        checks++;
        if (tv != c0 + 10 || fd !== ref_mem[fa]) begin
            errors++;
            $display("FAIL sim_fetch_valid: cycle %0d data %0h want cycle %0d data %0h",
                     tv, fd, c0 + 10, ref_mem[fa]);
        end
        checks++;
        if (erase_hi_cnt != 1) begin
            errors++;
            $display("FAIL sim_erase_width: got %0d want 1", erase_hi_cnt);
        end
        do_read(la, tg2, tv2, dat);
        checks++;
        if (dat !== ld) begin
            errors++;
            $display("FAIL sim_load_readback: got %0h want %0h", dat, ld);
        end
    endtask

    task automatic test_starvation();
        int ng, tf, tv;
        int gc [4];
        bit seq [4];
        bit exp_fetch;
        bit newl;
        apply_reset();
        ng = 0; newl = 0; tf = -1; tv = -1;
        @(negedge clk);
        load_req = 1; load_adrs = 6'($urandom_range(63, 0)); load_data = 8'($urandom_range(255, 0));
        fetch_req = 1; fetch_adrs = 6'($urandom_range(63, 0));
        for (int c = 0; c < 200 && ng < 4; c++) begin
            #1;
            if (load_gnt) begin
                seq[ng] = 0; gc[ng] = cyc; ng++; newl = 1;
                ref_mem[load_adrs] = load_data; known[load_adrs] = 1;
            end else if (fetch_gnt) begin
                seq[ng] = 1; gc[ng] = cyc; ng++;
            end
            @(negedge clk);
            if (newl) begin
                load_adrs = 6'($urandom_range(63, 0));
                load_data = 8'($urandom_range(255, 0));
                newl = 0;
            end
        end
        load_req = 0;
        checks++;
        if (ng != 4) begin
            errors++;
            $display("FAIL arb_grant_count: got %0d want 4", ng);
        end
        for (int i = 0; i < ng; i++) begin
`ifdef PRGM_ARB_RR_EN
            exp_fetch = (i % 2 == 1);
`else
            exp_fetch = 1'b0;
`endif
            checks++;
            if (seq[i] != exp_fetch) begin
                errors++;
                $display("FAIL arb_order_%0d: got fetch=%0d want fetch=%0d", i, seq[i], exp_fetch);
            end
            if (i > 0) begin
                checks++;
                if (gc[i] - gc[i-1] != 4) begin
                    errors++;
                    $display("FAIL arb_spacing_%0d: got %0d want 4", i, gc[i] - gc[i-1]);
                end
            end
        end
        for (int i = 0; i < 40; i++) begin
            #1;
            if (fetch_gnt) begin tf = cyc; break; end
            @(negedge clk);
        end
        checks++;
        if (ng != 4 || tf != gc[3] + 4) begin
            errors++;
            $display("FAIL arb_fetch_after_drop: cycle %0d want %0d", tf, gc[3] + 4);
        end
        @(negedge clk);
        fetch_req = 0;
        for (int i = 0; i < 40; i++) begin
            if (fetch_valid) begin tv = cyc; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_write();
        int tg;
        logic [5:0] a;
        a = 6'($urandom_range(63, 0));
        tg = -1;
        @(negedge clk);
        load_req = 1; load_adrs = a; load_data = 8'($urandom_range(255, 0));
        for (int i = 0; i < 40; i++) begin
            #1;
            if (load_gnt) begin tg = cyc; break; end
            @(negedge clk);
        end
        @(negedge clk);
        load_req = 0;
        @(negedge clk);
        checks++;
        if (tg < 0 || cyc != tg + 2 || mem_mode !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midwr_in_write: mode=%b busy=%b want 1 1", mem_mode, busy);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({busy, mem_mode, mem_erase, load_done, mem_adrs, mem_data} !== 18'b0) begin
            errors++;
            $display("FAIL midwr_async: busy=%b mode=%b adrs=%0h data=%0h want all 0",
                     busy, mem_mode, mem_adrs, mem_data);
        end
        known[a] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, mem_mode, load_done} !== 3'b0) begin
            errors++;
            $display("FAIL midwr_idle: busy=%b mode=%b done=%b want 0 0 0", busy, mem_mode, load_done);
        end
    endtask

    task automatic test_back_to_back();
        int tg, td, n, nv;
        int g [64];
        int v [64];
        logic [7:0] d [64];
        for (int a = 0; a < 64; a++) do_write(6'(a), 8'($urandom_range(255, 0)), tg, td);
        n = 0; nv = 0;
        @(negedge clk);
        fetch_req = 1; fetch_adrs = 6'd0;
        for (int c = 0; c < 400 && nv < 64; c++) begin
            #1;
            if (fetch_gnt && n < 64) begin g[n] = cyc; n++; end
            @(negedge clk);
            if (fetch_valid && nv < 64) begin v[nv] = cyc; d[nv] = fetch_data; nv++; end
            if (n >= 64) fetch_req = 0;
            else fetch_adrs = 6'(n);
        end
        fetch_req = 0;
        checks++;
        if (nv != 64 || n != 64) begin
            errors++;
            $display("FAIL b2b_count: gnts %0d valids %0d want 64 64", n, nv);
        end
        for (int i = 0; i < nv && i < n; i++) begin
            checks++;
            if (d[i] !== ref_mem[i] || v[i] != g[i] + 4) begin
                errors++;
                $display("FAIL b2b_read_%0d: data %0h lat %0d want %0h lat 4", i, d[i], v[i] - g[i], ref_mem[i]);
            end
            if (i < 63 && i + 1 < n) begin
                checks++;
                if (g[i+1] != v[i]) begin
                    errors++;
                    $display("FAIL b2b_gap_%0d: next gnt %0d want %0d", i, g[i+1], v[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; known[i] = 1; end
        test_reset();
        test_write_read();
        test_simultaneous();
        test_starvation();
        test_reset_mid_write();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
